// File: rtl/instr_retire_checker.sv
// rtl/instr_retire_checker.sv - shadow-model retire checker for the microcoded CPU
// Recomputes each retired instruction from shadow registers/flags and scores the DUT's reported effects.
module instr_retire_checker #(
    parameter int N     = 16,
    parameter int M     = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             ret_valid_i,
    input  logic [N-1:0]     ret_instr_i,
    input  logic [N-1:0]     ret_pc_i,
    input  logic [N-1:0]     ret_next_pc_i,
    input  logic             wb_en_i,
    input  logic [M-1:0]     wb_addr_i,
    input  logic [N-1:0]     wb_data_i,
    input  logic             mem_en_i,
    input  logic             mem_we_i,
    input  logic [N-1:0]     mem_addr_i,
    input  logic [N-1:0]     mem_data_i,
    output logic             chk_valid_o,
    output logic             chk_pass_o,
    output logic [2:0]       chk_code_o,
    output logic             err_sticky_o,
    output logic [N-1:0]     err_pc_o,
    output logic [N-1:0]     err_instr_o,
    input  logic [3:0]       rd_sel_i,
    output logic [CNT_W-1:0] rd_pass_o,
    output logic [CNT_W-1:0] rd_fail_o
);

    if (4 + 3 * M > N) begin : g_param_check
        $error("instr_retire_checker: 4+3*M must not exceed N");
    end

    localparam int NREG = 1 << M;
    localparam int IMM_W = N - 4 - M;
    localparam logic [M-1:0] PC_IDX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
        OP_XOR = 4'd4, OP_NOT = 4'd5, OP_MOV = 4'd6, OP_NOP = 4'd7,
        OP_LD  = 4'd8, OP_ST  = 4'd9, OP_LDI = 4'd10, OP_NU = 4'd11,
        OP_BRZ = 4'd12, OP_BRN = 4'd13, OP_BRO = 4'd14, OP_BRA = 4'd15
    } opcode_e;

    logic [N-1:0]     regs_q [NREG];
    logic             z_q, n_q, o_q;
    logic             armed_q;
    logic [N-1:0]     prev_next_pc_q;
    logic             chk_valid_q, chk_pass_q;
    logic [2:0]       chk_code_q;
    logic             err_sticky_q;
    logic [N-1:0]     err_pc_q, err_instr_q;
    logic [CNT_W-1:0] pass_cnt_q [16];
    logic [CNT_W-1:0] fail_cnt_q [16];
    logic [CNT_W-1:0] rd_pass_q, rd_fail_q;

    opcode_e          op;
    logic [M-1:0]     rd, ra, rb;
    logic [N-1:0]     a, b, imm_ldi, br_off;

    assign op      = opcode_e'(ret_instr_i[N-1 -: 4]);
    assign rd      = ret_instr_i[N-5 -: M];
    assign ra      = ret_instr_i[N-5-M -: M];
    assign rb      = ret_instr_i[N-5-2*M -: M];
    // The PC is not shadowed in the array; reading it yields the retiring instruction's address.
    assign a       = (ra == PC_IDX) ? ret_pc_i : regs_q[ra];
    assign b       = (rb == PC_IDX) ? ret_pc_i : regs_q[rb];
    assign imm_ldi = {{(N-IMM_W){ret_instr_i[IMM_W-1]}}, ret_instr_i[IMM_W-1:0]};
    assign br_off  = {{4{ret_instr_i[N-5]}}, ret_instr_i[N-5:0]};

    logic [N-1:0] res_d, exp_next_d;
    logic         ovf_d, set_flags_d, exp_wb_d, exp_mem_d, exp_we_d, taken_d;
    logic         mem_bad_d;
    logic [2:0]   code_d;

    always_comb begin
        res_d       = '0;
        ovf_d       = 1'b0;
        set_flags_d = 1'b0;
        exp_wb_d    = 1'b0;
        exp_mem_d   = 1'b0;
        exp_we_d    = 1'b0;
        taken_d     = 1'b0;
        exp_next_d  = ret_pc_i + N'(1);
        case (op)
            OP_ADD: begin
                res_d = a + b;
                ovf_d = (a[N-1] == b[N-1]) && (res_d[N-1] != a[N-1]);
                set_flags_d = 1'b1; exp_wb_d = 1'b1;
            end
            OP_SUB: begin
                res_d = a - b;
                ovf_d = (a[N-1] != b[N-1]) && (res_d[N-1] != a[N-1]);
                set_flags_d = 1'b1; exp_wb_d = 1'b1;
            end
            OP_AND: begin res_d = a & b; set_flags_d = 1'b1; exp_wb_d = 1'b1; end
            OP_OR:  begin res_d = a | b; set_flags_d = 1'b1; exp_wb_d = 1'b1; end
            OP_XOR: begin res_d = a ^ b; set_flags_d = 1'b1; exp_wb_d = 1'b1; end
            OP_NOT: begin res_d = ~a;    set_flags_d = 1'b1; exp_wb_d = 1'b1; end
            OP_MOV: begin res_d = a;     exp_wb_d = 1'b1; end
            OP_LD:  begin res_d = mem_data_i; exp_wb_d = 1'b1; exp_mem_d = 1'b1; end
            OP_ST:  begin exp_mem_d = 1'b1; exp_we_d = 1'b1; end
            OP_LDI: begin res_d = imm_ldi; exp_wb_d = 1'b1; end
            OP_NU:  exp_next_d = ret_pc_i;
            OP_BRZ: taken_d = z_q;
            OP_BRN: taken_d = n_q;
            OP_BRO: taken_d = o_q;
            OP_BRA: taken_d = 1'b1;
            default: ;
        endcase
        if (taken_d) exp_next_d = ret_pc_i + br_off;
        // A write to the PC register redirects control flow instead of producing a write-back.
        if (exp_wb_d && rd == PC_IDX) begin
            exp_wb_d   = 1'b0;
            exp_next_d = res_d;
        end

        mem_bad_d = (mem_en_i != exp_mem_d) ||
                    (exp_mem_d && ((mem_we_i != exp_we_d) || (mem_addr_i != a) ||
                                   (exp_we_d && mem_data_i != b)));

        code_d = 3'd0;
        if (armed_q && ret_pc_i != prev_next_pc_q)       code_d = 3'd6;
        if (mem_bad_d)                                   code_d = 3'd5;
        if (ret_next_pc_i != exp_next_d)                 code_d = 3'd4;
        if (exp_wb_d && wb_en_i && wb_data_i != res_d)   code_d = 3'd3;
        if (exp_wb_d && wb_en_i && wb_addr_i != rd)      code_d = 3'd2;
        if (wb_en_i != exp_wb_d)                         code_d = 3'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            for (int i = 0; i < 16; i++) begin
                pass_cnt_q[i] <= '0;
                fail_cnt_q[i] <= '0;
            end
            z_q            <= 1'b0;
            n_q            <= 1'b0;
            o_q            <= 1'b0;
            armed_q        <= 1'b0;
            prev_next_pc_q <= '0;
            chk_valid_q    <= 1'b0;
            chk_pass_q     <= 1'b0;
            chk_code_q     <= '0;
            err_sticky_q   <= 1'b0;
            err_pc_q       <= '0;
            err_instr_q    <= '0;
            rd_pass_q      <= '0;
            rd_fail_q      <= '0;
        end else begin
            rd_pass_q   <= pass_cnt_q[rd_sel_i];
            rd_fail_q   <= fail_cnt_q[rd_sel_i];
            chk_valid_q <= ret_valid_i;
            chk_pass_q  <= ret_valid_i && (code_d == 3'd0);
            chk_code_q  <= ret_valid_i ? code_d : 3'd0;
            if (ret_valid_i) begin
                if (exp_wb_d) regs_q[rd] <= res_d;
                if (set_flags_d) begin
                    z_q <= (res_d == '0);
                    n_q <= res_d[N-1];
                    o_q <= ovf_d;
                end
                armed_q        <= 1'b1;
                prev_next_pc_q <= ret_next_pc_i;
                if (code_d == 3'd0) begin
                    if (pass_cnt_q[op] != CNT_MAX) pass_cnt_q[op] <= pass_cnt_q[op] + CNT_W'(1);
                end else begin
                    if (fail_cnt_q[op] != CNT_MAX) fail_cnt_q[op] <= fail_cnt_q[op] + CNT_W'(1);
                    if (!err_sticky_q) begin
                        err_sticky_q <= 1'b1;
                        err_pc_q     <= ret_pc_i;
                        err_instr_q  <= ret_instr_i;
                    end
                end
            end
            // Clear overrides everything above except the shadow model and sequence tracking.
            if (clr_i) begin
                for (int i = 0; i < 16; i++) begin
                    pass_cnt_q[i] <= '0;
                    fail_cnt_q[i] <= '0;
                end
                chk_valid_q  <= 1'b0;
                chk_pass_q   <= 1'b0;
                chk_code_q   <= '0;
                err_sticky_q <= 1'b0;
                err_pc_q     <= '0;
                err_instr_q  <= '0;
                rd_pass_q    <= '0;
                rd_fail_q    <= '0;
            end
        end
    end

    assign chk_valid_o  = chk_valid_q;
    assign chk_pass_o   = chk_pass_q;
    assign chk_code_o   = chk_code_q;
    assign err_sticky_o = err_sticky_q;
    assign err_pc_o     = err_pc_q;
    assign err_instr_o  = err_instr_q;
    assign rd_pass_o    = rd_pass_q;
    assign rd_fail_o    = rd_fail_q;

endmodule

// File: tb/tb_instr_retire_checker.sv
// tb/tb_instr_retire_checker.sv - directed vector bench for instr_retire_checker
// N=16, M=3, CNT_W=4; encoding is {op[15:12], rd[11:9], ra[8:6], rb[5:3], 3'b0}.
module tb_instr_retire_checker;

    localparam int N = 16;
    localparam int M = 3;
    localparam int CNT_W = 4;
    localparam int NV = 19;

    logic             clk = 1'b0;
    logic             rst, clr, ret_valid;
    logic [N-1:0]     ret_instr, ret_pc, ret_next_pc;
    logic             wb_en;
    logic [M-1:0]     wb_addr;
    logic [N-1:0]     wb_data;
    logic             mem_en, mem_we;
    logic [N-1:0]     mem_addr, mem_data;
    logic             chk_valid, chk_pass;
    logic [2:0]       chk_code;
    logic             err_sticky;
    logic [N-1:0]     err_pc, err_instr;
    logic [3:0]       rd_sel;
    logic [CNT_W-1:0] rd_pass, rd_fail;

    always #5 clk = ~clk;

    instr_retire_checker #(.N(N), .M(M), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .ret_valid_i(ret_valid),
        .ret_instr_i(ret_instr), .ret_pc_i(ret_pc), .ret_next_pc_i(ret_next_pc),
        .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
        .mem_en_i(mem_en), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
        .chk_valid_o(chk_valid), .chk_pass_o(chk_pass), .chk_code_o(chk_code),
        .err_sticky_o(err_sticky), .err_pc_o(err_pc), .err_instr_o(err_instr),
        .rd_sel_i(rd_sel), .rd_pass_o(rd_pass), .rd_fail_o(rd_fail)
    );

    typedef struct {
        logic [N-1:0] instr, pc, npc;
        logic         wbe;
        logic [M-1:0] wba;
        logic [N-1:0] wbd;
        logic         me, mw;
        logic [N-1:0] ma, md;
        int           code;
    } vec_t;

    vec_t vecs [NV];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_pass_cnt [16];
    int   exp_fail_cnt [16];

    function automatic vec_t mk(input logic [N-1:0] instr, pc, npc, input logic wbe,
                                input logic [M-1:0] wba, input logic [N-1:0] wbd,
                                input logic me, mw, input logic [N-1:0] ma, md, input int code);
        vec_t v;
        v.instr = instr; v.pc = pc; v.npc = npc; v.wbe = wbe; v.wba = wba; v.wbd = wbd;
        v.me = me; v.mw = mw; v.ma = ma; v.md = md; v.code = code;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one retire, step one edge, and score the registered result.
    task automatic retire(input vec_t v, input string tag);
        ret_instr = v.instr; ret_pc = v.pc; ret_next_pc = v.npc;
        wb_en = v.wbe; wb_addr = v.wba; wb_data = v.wbd;
        mem_en = v.me; mem_we = v.mw; mem_addr = v.ma; mem_data = v.md;
        ret_valid = 1'b1;
        @(posedge clk); #1;
        ret_valid = 1'b0;
        check({tag, " chk_valid"}, 32'(chk_valid), 32'd1);
        check({tag, " chk_pass"},  32'(chk_pass),  32'(v.code == 0));
        check({tag, " chk_code"},  32'(chk_code),  32'(v.code));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(16'hA205, 16'h09, 16'h0A, 1, 1, 16'h0005, 0, 0, 0, 0, 0);      // LDI R1,5
        vecs[1]  = mk(16'hA403, 16'h0A, 16'h0B, 1, 2, 16'h0003, 0, 0, 0, 0, 0);      // LDI R2,3
        vecs[2]  = mk(16'h0650, 16'h0B, 16'h0C, 1, 3, 16'h0008, 0, 0, 0, 0, 0);      // ADD R3,R1,R2
        vecs[3]  = mk(16'h0650, 16'h0C, 16'h0D, 1, 3, 16'h0009, 0, 0, 0, 0, 3);      // wrong data
        vecs[4]  = mk(16'h8800, 16'h0D, 16'h0E, 1, 4, 16'h8000, 1, 0, 0, 16'h8000, 0); // LD R4,[R0]
        vecs[5]  = mk(16'hAA01, 16'h0E, 16'h0F, 1, 5, 16'h0001, 0, 0, 0, 0, 0);      // LDI R5,1
        vecs[6]  = mk(16'h1D28, 16'h0F, 16'h10, 1, 6, 16'h7FFF, 0, 0, 0, 0, 0);      // SUB overflows
        vecs[7]  = mk(16'hE004, 16'h10, 16'h11, 0, 0, 0, 0, 0, 0, 0, 4);             // BRO taken, DUT says 0x11
        vecs[8]  = mk(16'h9088, 16'h11, 16'h12, 0, 0, 0, 1, 0, 16'h3, 16'h5, 5);     // ST with we=0
        vecs[9]  = mk(16'h9088, 16'h12, 16'h13, 0, 0, 0, 1, 1, 16'h3, 16'h5, 0);     // ST ok
        vecs[10] = mk(16'h9088, 16'h13, 16'h14, 1, 0, 0, 1, 1, 16'h3, 16'h5, 1);     // ST with spurious wb
        vecs[11] = mk(16'hA3FF, 16'h14, 16'h15, 1, 1, 16'hFFFF, 0, 0, 0, 0, 0);      // LDI R1,-1
        vecs[12] = mk(16'h6440, 16'h15, 16'h16, 1, 2, 16'hFFFF, 0, 0, 0, 0, 0);      // MOV R2,R1 back-to-back
        vecs[13] = mk(16'hB000, 16'h16, 16'h16, 0, 0, 0, 0, 0, 0, 0, 0);             // NU holds PC
        vecs[14] = mk(16'h7000, 16'h16, 16'h17, 0, 0, 0, 0, 0, 0, 0, 0);             // NOP
        vecs[15] = mk(16'hFFFE, 16'h17, 16'h15, 0, 0, 0, 0, 0, 0, 0, 0);             // BRA -2
        vecs[16] = mk(16'hC005, 16'h15, 16'h16, 0, 0, 0, 0, 0, 0, 0, 0);             // BRZ not taken
        vecs[17] = mk(16'h7000, 16'h16, 16'h1F, 0, 0, 0, 0, 0, 0, 0, 4);             // NOP bad next PC
        vecs[18] = mk(16'h7000, 16'h20, 16'h21, 0, 0, 0, 0, 0, 0, 0, 6);             // PC sequence break
        for (int i = 0; i < 16; i++) begin
            exp_pass_cnt[i] = 0;
            exp_fail_cnt[i] = 0;
        end

        rst = 1'b1; clr = 1'b0; ret_valid = 1'b0; rd_sel = '0;
        ret_instr = '0; ret_pc = '0; ret_next_pc = '0; wb_en = 1'b0; wb_addr = '0;
        wb_data = '0; mem_en = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_data = '0;
        @(posedge clk); @(posedge clk); #1;
        check("reset chk_valid", 32'(chk_valid), 0);
        check("reset chk_code", 32'(chk_code), 0);
        check("reset err_sticky", 32'(err_sticky), 0);
        check("reset rd_pass", 32'(rd_pass), 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            retire(vecs[i], $sformatf("vec%0d", i));
            if (vecs[i].code == 0) exp_pass_cnt[vecs[i].instr[15:12]]++;
            else                   exp_fail_cnt[vecs[i].instr[15:12]]++;
        end

        check("err_sticky", 32'(err_sticky), 1);
        check("err_pc first", 32'(err_pc), 32'h0C);
        check("err_instr first", 32'(err_instr), 32'h0650);

        for (int op = 0; op < 16; op++) begin
            rd_sel = 4'(op);
            @(posedge clk); #1;
            check($sformatf("rd_pass op%0d", op), 32'(rd_pass), 32'(exp_pass_cnt[op]));
            check($sformatf("rd_fail op%0d", op), 32'(rd_fail), 32'(exp_fail_cnt[op]));
        end

        // Clear with a retire in the same cycle: result dropped, shadow still updated.
        rd_sel = 4'd7;
        clr = 1'b1;
        ret_instr = 16'hA607; ret_pc = 16'h21; ret_next_pc = 16'h22;
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h7; mem_en = 1'b0;
        ret_valid = 1'b1;
        @(posedge clk); #1;
        ret_valid = 1'b0; clr = 1'b0;
        check("clr chk_valid", 32'(chk_valid), 0);
        check("clr err_sticky", 32'(err_sticky), 0);
        check("clr err_pc", 32'(err_pc), 0);
        check("clr rd_fail", 32'(rd_fail), 0);
        retire(mk(16'h68C0, 16'h22, 16'h23, 1, 4, 16'h0007, 0, 0, 0, 0, 0), "mov after clr");
        check("post-clr rd_fail op7", 32'(rd_fail), 0);
        check("post-clr rd_pass op7", 32'(rd_pass), 0);

        // Saturation: readback at each update edge shows the pre-update count.
        for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
            retire(mk(16'h7000, 16'(16'h23 + k), 16'(16'h24 + k), 0, 0, 0, 0, 0, 0, 0, 0),
                   $sformatf("nop%0d", k));
            check($sformatf("nop%0d rd_pass", k), 32'(rd_pass), 32'((k < 15) ? k : 15));
        end
        @(posedge clk); #1;
        check("rd_pass saturated", 32'(rd_pass), 15);

        retire(mk(16'h7000, 16'h36, 16'h37, 0, 0, 0, 0, 0, 0, 0, 0), "nop pre-rst");
        #2 rst = 1'b1;
        #1;
        check("async rst chk_valid", 32'(chk_valid), 0);
        check("async rst chk_pass", 32'(chk_pass), 0);
        check("async rst rd_pass", 32'(rd_pass), 0);
        check("async rst err_sticky", 32'(err_sticky), 0);
        @(negedge clk);
        rst = 1'b0;
        retire(mk(16'h7000, 16'h100, 16'h101, 0, 0, 0, 0, 0, 0, 0, 0), "first after rst");
        retire(mk(16'h0250, 16'h101, 16'h102, 1, 1, 16'h0000, 0, 0, 0, 0, 0), "add zeroed regs");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
